// File: rtl/falling_letter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------------------------+
// | falling_letter_ctrl : falling-letter game state (spawn, fall, key match, score and lives).      |
// | Optional macro SPEEDUP_EN: every 8th hit halves the fall divider, up to three times.           |
// | Revision: 1.0                                                                                  |
// +----------------------------------------------------------------------------------------------+
module falling_letter_ctrl #(
    parameter int SLOTS       = 4,
    parameter int Y_TOP       = 0,
    parameter int Y_BOTTOM    = 464,
    parameter int FALL_DIV    = 833333,
    parameter int SPAWN_TICKS = 40,
    parameter int GEN_LAT     = 3,
    parameter int LIVES       = 5
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 run,
    output logic                 gen_req,
    input  logic [9:0]           gen_x,
    input  logic [7:0]           gen_asc,
    input  logic [143:0]         gen_font,
    input  logic                 key_valid,
    input  logic [7:0]           key_asc,
    output logic [SLOTS-1:0]     slot_valid,
    output logic [SLOTS*10-1:0]  slot_x,
    output logic [SLOTS*10-1:0]  slot_y,
    output logic [SLOTS*8-1:0]   slot_asc,
    output logic [SLOTS*144-1:0] slot_font,
    output logic [9:0]           score,
    output logic [2:0]           lives,
    output logic                 hit,
    output logic                 wrong_key,
    output logic                 game_over
);
    localparam int DIV_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam int SPN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam int LAT_W = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] req_cnt_q, req_cnt_d;
    logic [DIV_W-1:0] div_q, div_d, div_last;
    logic [SPN_W-1:0] spawn_q, spawn_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [9:0]       x_q    [SLOTS];
    logic [9:0]       x_d    [SLOTS];
    logic [9:0]       y_q    [SLOTS];
    logic [9:0]       y_d    [SLOTS];
    logic [7:0]       asc_q  [SLOTS];
    logic [7:0]       asc_d  [SLOTS];
    logic [143:0]     font_q [SLOTS];
    logic [143:0]     font_d [SLOTS];
    logic [9:0]       score_q, score_d;
    logic [2:0]       lives_q, lives_d;
    logic             hit_q, hit_d, wrong_q, wrong_d, over_q, over_d;

    logic             active, tick, attempt, key_hit, free_found;
    logic [IDX_W-1:0] win_idx, free_idx;
    logic [9:0]       best_y, y_inc;
    logic [3:0]       drops;

`ifdef SPEEDUP_EN
    logic [1:0] n_q, n_d;
    logic [2:0] hcnt_q, hcnt_d;

    always_comb begin
        if ((FALL_DIV >> n_q) > 1) div_last = DIV_W'((FALL_DIV >> n_q) - 1);
        else                       div_last = '0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            n_q    <= 2'd0;
            hcnt_q <= 3'd0;
        end else begin
            n_q    <= n_d;
            hcnt_q <= hcnt_d;
        end
    end
`else
    assign div_last = DIV_W'(FALL_DIV - 1);
`endif

    assign active = run && !over_q;

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        div_d      = div_q;
        spawn_d    = spawn_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        asc_d      = asc_q;
        font_d     = font_q;
        score_d    = score_q;
        lives_d    = lives_q;
        hit_d      = 1'b0;
        wrong_d    = 1'b0;
        over_d     = over_q;
        tick       = 1'b0;
        attempt    = 1'b0;
        key_hit    = 1'b0;
        free_found = 1'b0;
        win_idx    = '0;
        free_idx   = '0;
        best_y     = '0;
        y_inc      = '0;
        drops      = '0;
`ifdef SPEEDUP_EN
        n_d        = n_q;
        hcnt_d     = hcnt_q;
`endif

        if (active) begin
            if (div_q >= div_last) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        // Deepest matching letter wins; strict '>' keeps the lowest index on a tie.
        if (active && key_valid) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (valid_q[i] && asc_q[i] == key_asc && (!key_hit || y_q[i] > best_y)) begin
                    key_hit = 1'b1;
                    win_idx = IDX_W'(i);
                    best_y  = y_q[i];
                end
            end
            if (key_hit) begin
                valid_d[win_idx] = 1'b0;
                hit_d            = 1'b1;
                if (score_q != 10'h3FF) score_d = score_q + 10'd1;
`ifdef SPEEDUP_EN
                hcnt_d = hcnt_q + 3'd1;
                if (hcnt_q == 3'd7 && n_q != 2'd3) begin
                    n_d   = n_q + 2'd1;
                    div_d = '0;
                end
`endif
            end else begin
                wrong_d = 1'b1;
            end
        end

        if (tick) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (valid_q[i] && !(key_hit && win_idx == IDX_W'(i))) begin
                    y_inc  = y_q[i] + 10'd1;
                    y_d[i] = y_inc;
                    if (y_inc >= 10'(Y_BOTTOM)) begin
                        valid_d[i] = 1'b0;
                        drops      = drops + 4'd1;
                    end
                end
            end
            if (spawn_q == SPN_W'(SPAWN_TICKS - 1)) begin
                spawn_d = '0;
                attempt = 1'b1;
            end else begin
                spawn_d = spawn_q + 1'b1;
            end
        end

        if ({1'b0, lives_q} > drops) lives_d = lives_q - drops[2:0];
        else                         lives_d = 3'd0;
        if (lives_d == 3'd0) over_d = 1'b1;

        // Only slots already empty this cycle are eligible, so a same-cycle clear is never reused.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (attempt && free_found) begin
                    state_d   = ST_REQ;
                    req_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end else if (req_cnt_q == LAT_W'(GEN_LAT - 1)) begin
                    state_d = ST_IDLE;
                    if (gen_asc >= 8'h61 && gen_asc <= 8'h7a && free_found) begin
                        valid_d[free_idx] = 1'b1;
                        x_d[free_idx]     = gen_x;
                        y_d[free_idx]     = 10'(Y_TOP);
                        asc_d[free_idx]   = gen_asc;
                        font_d[free_idx]  = gen_font;
                    end
                end else begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            req_cnt_q <= '0;
            div_q     <= '0;
            spawn_q   <= '0;
            valid_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                asc_q[i]  <= '0;
                font_q[i] <= '0;
            end
            score_q   <= '0;
            lives_q   <= 3'(LIVES);
            hit_q     <= 1'b0;
            wrong_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            div_q     <= div_d;
            spawn_q   <= spawn_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            asc_q     <= asc_d;
            font_q    <= font_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            wrong_q   <= wrong_d;
            over_q    <= over_d;
        end
    end

    generate
        for (genvar g = 0; g < SLOTS; g++) begin : g_slot
            assign slot_x[g*10 +: 10]     = x_q[g];
            assign slot_y[g*10 +: 10]     = y_q[g];
            assign slot_asc[g*8 +: 8]     = asc_q[g];
            assign slot_font[g*144 +: 144] = font_q[g];
        end
    endgenerate

    assign gen_req    = (state_q == ST_REQ);
    assign slot_valid = valid_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign hit        = hit_q;
    assign wrong_key  = wrong_q;
    assign game_over  = over_q;

endmodule
`default_nettype wire

// File: tb/tb_falling_letter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------------------------+
// | tb_falling_letter_ctrl : random game traffic compared against a slot-list game model.          |
// | Revision: 1.0                                                                                  |
// +----------------------------------------------------------------------------------------------+
module tb_falling_letter_ctrl;
    localparam int SLOTS = 4, Y_TOP = 0, Y_BOTTOM = 20, FALL_DIV = 4;
    localparam int SPAWN_TICKS = 2, GEN_LAT = 3, LIVES = 2;

    logic                 clk = 1'b0, clrn = 1'b0, run = 1'b0, key_valid = 1'b0;
    logic [9:0]           gen_x = '0;
    logic [7:0]           gen_asc = '0, key_asc = '0;
    logic [143:0]         gen_font = '0;
    logic                 gen_req, hit, wrong_key, game_over;
    logic [SLOTS-1:0]     slot_valid;
    logic [SLOTS*10-1:0]  slot_x, slot_y;
    logic [SLOTS*8-1:0]   slot_asc;
    logic [SLOTS*144-1:0] slot_font;
    logic [9:0]           score;
    logic [2:0]           lives;

    falling_letter_ctrl #(
        .SLOTS(SLOTS), .Y_TOP(Y_TOP), .Y_BOTTOM(Y_BOTTOM), .FALL_DIV(FALL_DIV),
        .SPAWN_TICKS(SPAWN_TICKS), .GEN_LAT(GEN_LAT), .LIVES(LIVES)
    ) dut (
        .clk(clk), .clrn(clrn), .run(run), .gen_req(gen_req), .gen_x(gen_x),
        .gen_asc(gen_asc), .gen_font(gen_font), .key_valid(key_valid), .key_asc(key_asc),
        .slot_valid(slot_valid), .slot_x(slot_x), .slot_y(slot_y), .slot_asc(slot_asc),
        .slot_font(slot_font), .score(score), .lives(lives), .hit(hit),
        .wrong_key(wrong_key), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        int           x;
        int           y;
        int           asc;
        logic [143:0] font;
    } slot_t;

    slot_t ms [SLOTS];
    int    m_score, m_lives, m_cyc_since_tick, m_ticks, m_req_left, m_speed, m_hits;
    bit    m_hit, m_wrong, m_over;
    int    checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) ms[i] = '{0, 0, 0, 0, '0};
        m_score = 0; m_lives = LIVES; m_cyc_since_tick = 0; m_ticks = 0;
        m_req_left = 0; m_speed = 0; m_hits = 0;
        m_hit = 0; m_wrong = 0; m_over = 0;
    endtask

    // Advances the game by one clock using the inputs about to be sampled.
    task automatic model_step(input bit r, input bit kv, input int ka,
                              input int gx, input int ga, input logic [143:0] gf);
        slot_t nx [SLOTS];
        int    period, win, best, drops, free;
        bit    act, tick;
        nx = ms;
        act = r && !m_over;
        period = FALL_DIV >> m_speed;
        if (period < 1) period = 1;
        tick = 0;
        if (act) begin
            m_cyc_since_tick++;
            if (m_cyc_since_tick >= period) begin
                m_cyc_since_tick = 0;
                tick = 1;
            end
        end
        m_hit = 0; m_wrong = 0; win = -1; best = -1;
        if (act && kv) begin
            for (int i = 0; i < SLOTS; i++)
                if (ms[i].v && ms[i].asc == ka && ms[i].y > best) begin
                    win = i; best = ms[i].y;
                end
            if (win >= 0) begin
                nx[win].v = 0; m_hit = 1;
                if (m_score < 1023) m_score++;
`ifdef SPEEDUP_EN
                m_hits++;
                if (m_hits % 8 == 0 && m_speed < 3) begin
                    m_speed++; m_cyc_since_tick = 0;
                end
`endif
            end else begin
                m_wrong = 1;
            end
        end
        drops = 0;
        free = -1;
        for (int i = SLOTS - 1; i >= 0; i--) if (!ms[i].v) free = i;
        if (tick) begin
            for (int i = 0; i < SLOTS; i++)
                if (ms[i].v && i != win) begin
                    nx[i].y = ms[i].y + 1;
                    if (nx[i].y >= Y_BOTTOM) begin nx[i].v = 0; drops++; end
                end
            m_ticks++;
        end
        if (m_req_left > 0) begin
            if (!act) m_req_left = 0;
            else if (m_req_left == 1) begin
                m_req_left = 0;
                if (ga >= 'h61 && ga <= 'h7a && free >= 0) nx[free] = '{1, gx, Y_TOP, ga, gf};
            end else m_req_left--;
        end else if (tick && m_ticks % SPAWN_TICKS == 0 && free >= 0) begin
            m_req_left = GEN_LAT;
        end
        m_lives = (m_lives > drops) ? m_lives - drops : 0;
        if (m_lives == 0) m_over = 1;
        ms = nx;
    endtask

    task automatic check_all();
        logic [SLOTS-1:0] vm;
        for (int i = 0; i < SLOTS; i++) vm[i] = ms[i].v;
        chk("slot_valid", 144'(slot_valid), 144'(vm));
        for (int i = 0; i < SLOTS; i++) if (ms[i].v) begin
            chk($sformatf("slot_x%0d", i), 144'(slot_x[i*10 +: 10]), 144'(ms[i].x));
            chk($sformatf("slot_y%0d", i), 144'(slot_y[i*10 +: 10]), 144'(ms[i].y));
            chk($sformatf("slot_asc%0d", i), 144'(slot_asc[i*8 +: 8]), 144'(ms[i].asc));
            chk($sformatf("slot_font%0d", i), slot_font[i*144 +: 144], ms[i].font);
        end
        chk("gen_req", 144'(gen_req), 144'(m_req_left > 0));
        chk("score", 144'(score), 144'(m_score));
        chk("lives", 144'(lives), 144'(m_lives));
        chk("hit", 144'(hit), 144'(m_hit));
        chk("wrong_key", 144'(wrong_key), 144'(m_wrong));
        chk("game_over", 144'(game_over), 144'(m_over));
    endtask

    task automatic check_reset();
        chk("rst_valid", 144'(slot_valid), 144'(0));
        chk("rst_x", 144'(slot_x), 144'(0));
        chk("rst_y", 144'(slot_y), 144'(0));
        chk("rst_asc", 144'(slot_asc), 144'(0));
        chk("rst_font_or", 144'(|slot_font), 144'(0));
        chk("rst_gen_req", 144'(gen_req), 144'(0));
        chk("rst_score", 144'(score), 144'(0));
        chk("rst_lives", 144'(lives), 144'(LIVES));
        chk("rst_flags", 144'({hit, wrong_key, game_over}), 144'(0));
    endtask

    initial begin
        int len, kp, pick;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset();
        clrn = 1'b1;
        for (int ep = 0; ep < 30 && errors < 20; ep++) begin
            len = $urandom_range(300, 900);
            kp  = $urandom_range(2, 40);
            for (int c = 0; c < len && errors < 20; c++) begin
                @(negedge clk);
                check_all();
                run       = ($urandom_range(0, 31) != 0);
                key_valid = ($urandom_range(0, kp - 1) == 0);
                if ($urandom_range(0, 1) == 1) key_asc = 8'(ms[$urandom_range(0, SLOTS - 1)].asc);
                else key_asc = ($urandom_range(0, 4) == 4) ? 8'h7a : 8'(8'h61 + $urandom_range(0, 3));
                pick = $urandom_range(0, 9);
                gen_asc  = (pick == 0) ? 8'h00 : (pick == 1) ? 8'($urandom) : 8'(8'h61 + $urandom_range(0, 3));
                gen_x    = 10'($urandom);
                gen_font = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
                model_step(run, key_valid, int'(key_asc), int'(gen_x), int'(gen_asc), gen_font);
            end
            // Asynchronous reset dropped mid-cycle, away from any edge.
            @(posedge clk);
            #2 clrn = 1'b0;
            run = 1'b0;
            key_valid = 1'b0;
            #1;
            model_reset();
            check_reset();
            @(negedge clk);
            clrn = 1'b1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
